fpu_issue_stage: RTL



---
 rtl/fpu_issue_stage.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/fpu_issue_stage.sv
// Issue/capture stage in front of the combinational fpu: registers one
// operation onto the fpu inputs, waits a per-opcode latency budget, then
// captures the result and hands it to writeback over a valid/ready handshake.
module fpu_issue_stage #(
  parameter int MUL_LAT  = 2,
  parameter int DIV_LAT  = 8,
  parameter int FMA_LAT  = 3,
  parameter int BASE_LAT = 1
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        IN_VALID,
  output logic        IN_READY,
  input  logic [31:0] IN_DATA1,
  input  logic [31:0] IN_DATA2,
  input  logic [31:0] IN_DATA3,
  input  logic [4:0]  IN_SELECT,
  input  logic [4:0]  IN_RD,
  output logic [31:0] FPU_DATA1,
  output logic [31:0] FPU_DATA2,
  output logic [31:0] FPU_DATA3,
  output logic [4:0]  FPU_SELECT,
  input  logic [31:0] FPU_RESULT,
  output logic        OUT_VALID,
  input  logic        OUT_READY,
  output logic [31:0] OUT_RESULT,
  output logic [4:0]  OUT_RD,
  output logic        OUT_INT,
  output logic        BUSY
);

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [4:0]  rd_q;
  logic        int_q;
  logic        accept;
  logic        capture;

  // Latency budget minus one, so the counter reaches zero on the capture cycle
  function automatic logic [3:0] lat_m1(input logic [4:0] sel);
    int lat;
    case (sel)
      5'b00011:                               lat = MUL_LAT;
      5'b00100:                               lat = DIV_LAT;
      5'b01110, 5'b01111, 5'b10000, 5'b10001: lat = FMA_LAT;
      default:                                lat = BASE_LAT;
    endcase
    return 4'(lat - 1);
  endfunction

  // Opcodes whose result goes to the integer register file
  function automatic logic int_dest(input logic [4:0] sel);
    case (sel)
      5'b01010, 5'b01011, 5'b01100,
      5'b10010, 5'b10011, 5'b10100: return 1'b1;
      default:                      return 1'b0;
    endcase
  endfunction

  assign IN_READY = (state_q == IDLE) | ((state_q == DONE) & OUT_READY);
  assign accept   = IN_VALID & IN_READY;
  assign BUSY     = (state_q != IDLE);

  // Next-state and counter logic; DONE can hand straight over to a new op
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = EXEC;
          cnt_d   = lat_m1(IN_SELECT);
        end
      end
      EXEC: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          capture = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        if (OUT_READY) begin
          if (accept) begin
            state_d = EXEC;
            cnt_d   = lat_m1(IN_SELECT);
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // State and latency counter registers
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Operand, opcode and tag registers only move on an accepted operation
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      FPU_DATA1  <= 32'd0;
      FPU_DATA2  <= 32'd0;
      FPU_DATA3  <= 32'd0;
      FPU_SELECT <= 5'd0;
      rd_q       <= 5'd0;
      int_q      <= 1'b0;
    end else if (accept) begin
      FPU_DATA1  <= IN_DATA1;
      FPU_DATA2  <= IN_DATA2;
      FPU_DATA3  <= IN_DATA3;
      FPU_SELECT <= IN_SELECT;
      rd_q       <= IN_RD;
      int_q      <= int_dest(IN_SELECT);
    end
  end

  // Result capture and writeback valid; data holds until the next capture
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      OUT_VALID  <= 1'b0;
      OUT_RESULT <= 32'd0;
      OUT_RD     <= 5'd0;
      OUT_INT    <= 1'b0;
    end else if (capture) begin
      OUT_VALID  <= 1'b1;
      OUT_RESULT <= FPU_RESULT;
      OUT_RD     <= rd_q;
      OUT_INT    <= int_q;
    end else if ((state_q == DONE) && OUT_READY) begin
      OUT_VALID  <= 1'b0;
    end
  end

endmodule
